// File: rtl/data_memory.sv
// 128 x 32 word-addressed data memory: combinational read, edge-committed write, sticky strobe-error flag.
// Optional access counters are built only when DMEM_ACCESS_CNT_EN is defined.
module data_memory #(
    parameter int DEPTH = 128,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          CEN,
    input  logic          WEN,
    input  logic          OEN,
    input  logic [6:0]    A,
    input  logic [DW-1:0] D,
    output logic [DW-1:0] Q,
    output logic          err,
    output logic [15:0]   rd_cnt,
    output logic [15:0]   wr_cnt
);

    logic [DW-1:0] mem [DEPTH];
    logic          rd_en;
    logic          wr_en;
    logic          err_set;

    // Unknown strobes fall through every if-test, so they decode as idle.
    always_comb begin
        rd_en = 1'b0;
        wr_en = 1'b0;
        if (rst_n && !CEN) begin
            if (!WEN)
                wr_en = 1'b1;
            else if (WEN && !OEN)
                rd_en = 1'b1;
        end
    end

    assign err_set = wr_en && !OEN;

    always_comb begin
        Q = '0;
        if (rd_en)
            Q = mem[A];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_en) begin
            mem[A] <= D;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else if (err_set)
            err <= 1'b1;
    end

`ifdef DMEM_ACCESS_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt <= 16'h0000;
            wr_cnt <= 16'h0000;
        end else begin
            if (rd_en)
                rd_cnt <= sat_inc(rd_cnt);
            if (wr_en)
                wr_cnt <= sat_inc(wr_cnt);
        end
    end
`else
    assign rd_cnt = 16'h0000;
    assign wr_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: reference model plus a queue of expected Q values.
module tb_data_memory;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        CEN = 1'b1;
    logic        WEN = 1'b1;
    logic        OEN = 1'b1;
    logic [6:0]  A = '0;
    logic [31:0] D = '0;
    logic [31:0] Q;
    logic        err;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    int checks = 0;
    int failures = 0;

    logic [31:0] mdl_mem [128];
    logic        mdl_err;
    logic [15:0] mdl_rd;
    logic [15:0] mdl_wr;
    logic [31:0] exp_q [$];

    data_memory dut (
        .clk(clk), .rst_n(rst_n), .CEN(CEN), .WEN(WEN), .OEN(OEN),
        .A(A), .D(D), .Q(Q), .err(err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 128; i++)
            mdl_mem[i] = 32'h0;
        mdl_err = 1'b0;
        mdl_rd  = 16'h0;
        mdl_wr  = 16'h0;
    endtask

    // Drive one request and queue the Q the model predicts for it.
    task automatic apply(input logic cen, input logic wen, input logic oen,
                         input logic [6:0] a, input logic [31:0] d);
        CEN = cen; WEN = wen; OEN = oen; A = a; D = d;
        if (rst_n && !cen && wen && !oen)
            exp_q.push_back(mdl_mem[a]);
        else
            exp_q.push_back(32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n && !CEN) begin
            if (!WEN) begin
                mdl_mem[A] = D;
                if (!OEN) mdl_err = 1'b1;
`ifdef DMEM_ACCESS_CNT_EN
                if (mdl_wr != 16'hFFFF) mdl_wr = mdl_wr + 16'd1;
`endif
            end else if (!OEN) begin
`ifdef DMEM_ACCESS_CNT_EN
                if (mdl_rd != 16'hFFFF) mdl_rd = mdl_rd + 16'd1;
`endif
            end
        end
        #1;
    endtask

    task automatic pulse_reset();
        CEN = 1'b1; WEN = 1'b1; OEN = 1'b1;
        #1 rst_n = 1'b0;
        model_clear();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        model_clear();
        #3;
        checks++;
        if (Q !== 32'h0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_q_err: Q=%h err=%b required Q=0 err=0", Q, err);
        end
        checks++;
        if (rd_cnt !== 16'h0 || wr_cnt !== 16'h0) begin
            failures++;
            $display("FAIL reset_cnt: rd=%h wr=%h required 0/0", rd_cnt, wr_cnt);
        end
        // Write attempted while reset is held must be dropped.
        apply(1'b0, 1'b0, 1'b1, 7'd9, 32'h12345678);
        void'(exp_q.pop_front());
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [6:0] a;
            a = (i == 0) ? 7'd0 : (i == 1) ? 7'd127 : 7'd9;
            apply(1'b0, 1'b1, 1'b0, a, 32'h0);
            #2;
            e = exp_q.pop_front();
            checks++;
            if (Q !== e || e !== 32'h0) begin
                failures++;
                $display("FAIL reset_read[%0d]: Q=%h required %h", a, Q, 32'h0);
            end
            tick();
        end
        checks++;
        if (err !== 1'b0 || rd_cnt !== mdl_rd || wr_cnt !== 16'h0) begin
            failures++;
            $display("FAIL reset_after_reads: err=%b rd=%h wr=%h required 0 %h 0", err, rd_cnt, wr_cnt, mdl_rd);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] e;
        pulse_reset();
        apply(1'b0, 1'b0, 1'b1, 7'd5, 32'hDEADBEEF);
        #2 e = exp_q.pop_front();
        checks++;
        if (Q !== e) begin
            failures++;
            $display("FAIL wr_q_during_write: Q=%h required %h", Q, e);
        end
        tick();
        apply(1'b0, 1'b1, 1'b0, 7'd5, 32'h0);
        #2 e = exp_q.pop_front();
        checks++;
        if (Q !== e || e !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL raw_a5: Q=%h required %h", Q, 32'hDEADBEEF);
        end
        tick();
        checks++;
`ifdef DMEM_ACCESS_CNT_EN
        if (rd_cnt !== 16'd1 || wr_cnt !== 16'd1) begin
`else
        if (rd_cnt !== 16'd0 || wr_cnt !== 16'd0) begin
`endif
            failures++;
            $display("FAIL wr_counts: rd=%h wr=%h required %h %h", rd_cnt, wr_cnt, mdl_rd, mdl_wr);
        end
        apply(1'b0, 1'b1, 1'b0, 7'd6, 32'h0);
        #2 e = exp_q.pop_front();
        checks++;
        if (Q !== e) begin
            failures++;
            $display("FAIL read_a6: Q=%h required %h", Q, e);
        end
        tick();
        // Idle strobes: OEN high and CEN high must both read as zero.
        apply(1'b0, 1'b1, 1'b1, 7'd5, 32'h0);
        #2 e = exp_q.pop_front();
        checks++;
        if (Q !== e) begin
            failures++;
            $display("FAIL idle_oen: Q=%h required %h", Q, e);
        end
        tick();
        apply(1'b1, 1'b0, 1'b0, 7'd5, 32'h55555555);
        #2 e = exp_q.pop_front();
        checks++;
        if (Q !== e) begin
            failures++;
            $display("FAIL idle_cen: Q=%h required %h", Q, e);
        end
        tick();
        apply(1'b0, 1'b1, 1'b0, 7'd5, 32'h0);
        #2 e = exp_q.pop_front();
        checks++;
        if (Q !== e) begin
            failures++;
            $display("FAIL idle_no_write: Q=%h required %h", Q, e);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b0, 1'b1, 7'd64, 32'(i + 1));
            #2 e = exp_q.pop_front();
            checks++;
            if (Q !== e) begin
                failures++;
                $display("FAIL b2b_q_write%0d: Q=%h required %h", i, Q, e);
            end
            tick();
        end
        apply(1'b0, 1'b1, 1'b0, 7'd64, 32'h0);
        #2 e = exp_q.pop_front();
        checks++;
        if (Q !== e || e !== 32'h2) begin
            failures++;
            $display("FAIL b2b_last_wins: Q=%h required %h", Q, 32'h2);
        end
        tick();
    endtask

    task automatic test_pattern();
        logic [31:0] e;
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 1'b0, 1'b1, 7'((i * 37 + 11) % 128), $urandom);
            #2 void'(exp_q.pop_front());
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 1'b1, 1'b0, 7'((i * 37 + 11) % 128), 32'h0);
            #2 e = exp_q.pop_front();
            checks++;
            if (Q !== e) begin
                failures++;
                $display("FAIL pattern_read[%0d]: Q=%h required %h", (i * 37 + 11) % 128, Q, e);
            end
            tick();
        end
        checks++;
        if (rd_cnt !== mdl_rd || wr_cnt !== mdl_wr || err !== 1'b0) begin
            failures++;
            $display("FAIL pattern_state: rd=%h wr=%h err=%b required %h %h 0", rd_cnt, wr_cnt, err, mdl_rd, mdl_wr);
        end
    endtask

    task automatic test_protocol_error();
        logic [31:0] e;
        apply(1'b0, 1'b0, 1'b0, 7'd3, 32'hA5A5A5A5);
        #2 e = exp_q.pop_front();
        checks++;
        if (Q !== e) begin
            failures++;
            $display("FAIL perr_q: Q=%h required %h", Q, e);
        end
        tick();
        checks++;
        if (err !== mdl_err || mdl_err !== 1'b1) begin
            failures++;
            $display("FAIL perr_set: err=%b required 1", err);
        end
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, 1'b1, 1'b1, 7'd0, 32'h0);
            void'(exp_q.pop_front());
            tick();
        end
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL perr_sticky: err=%b required 1", err);
        end
        apply(1'b0, 1'b1, 1'b0, 7'd3, 32'h0);
        #2 e = exp_q.pop_front();
        checks++;
        if (Q !== e || e !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL perr_write_commits: Q=%h required %h", Q, 32'hA5A5A5A5);
        end
        tick();
        checks++;
        if (wr_cnt !== mdl_wr || rd_cnt !== mdl_rd) begin
            failures++;
            $display("FAIL perr_counts: rd=%h wr=%h required %h %h", rd_cnt, wr_cnt, mdl_rd, mdl_wr);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] e;
        apply(1'b0, 1'b0, 1'b1, 7'd3, 32'h0BADF00D);
        #2 void'(exp_q.pop_front());
        tick();
        apply(1'b0, 1'b1, 1'b0, 7'd3, 32'h0);
        #2 e = exp_q.pop_front();
        checks++;
        if (Q !== e || e !== 32'h0BADF00D) begin
            failures++;
            $display("FAIL mid_pre_read: Q=%h required %h", Q, 32'h0BADF00D);
        end
        #1 rst_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if (Q !== 32'h0 || err !== 1'b0 || rd_cnt !== 16'h0 || wr_cnt !== 16'h0) begin
            failures++;
            $display("FAIL mid_async: Q=%h err=%b rd=%h wr=%h required 0 0 0 0", Q, err, rd_cnt, wr_cnt);
        end
        #2 rst_n = 1'b1;
        tick();
        apply(1'b0, 1'b1, 1'b0, 7'd3, 32'h0);
        #2 e = exp_q.pop_front();
        checks++;
        if (Q !== e || e !== 32'h0) begin
            failures++;
            $display("FAIL mid_cleared: Q=%h required %h", Q, 32'h0);
        end
        tick();
    endtask

    task automatic test_saturation();
        pulse_reset();
        apply(1'b0, 1'b1, 1'b0, 7'd0, 32'h0);
        void'(exp_q.pop_front());
`ifdef DMEM_ACCESS_CNT_EN
        repeat (65540) @(posedge clk);
        #1;
        mdl_rd = 16'hFFFF;
`else
        repeat (200) @(posedge clk);
        #1;
`endif
        checks++;
        if (rd_cnt !== mdl_rd || wr_cnt !== 16'h0) begin
            failures++;
            $display("FAIL saturation: rd=%h wr=%h required %h 0", rd_cnt, wr_cnt, mdl_rd);
        end
        tick();
        checks++;
        if (rd_cnt !== mdl_rd) begin
            failures++;
            $display("FAIL saturation_hold: rd=%h required %h", rd_cnt, mdl_rd);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_pattern();
        test_protocol_error();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
